muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer with HI/LO registers for the single-cycle MIPS core. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from `op_c`/`funct` and runs a shift-add multiply or restoring divide over WIDTH+1 cycles. It drives `stall` so the core holds PC and instruction while a HI/LO-dependent instruction waits on a busy unit. It sits beside the ALU; `mf_data` feeds the register-file write-back mux.

---
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Decode-stage bundle between the core and the HI/LO multiply/divide sequencer.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [5:0]       op_c;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;
    logic             mf_valid;

    modport master (
        output en, op_c, funct, src_a, src_b,
        input  stall, busy, hi, lo, mf_data, mf_valid
    );
    modport slave (
        input  en, op_c, funct, src_a, src_b,
        output stall, busy, hi, lo, mf_data, mf_valid
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers and
// a decode-stage interlock for HI/LO-dependent instructions.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // Order of this table fixes the meaning of each hit[] bit below.
    localparam logic [5:0] FUNCT_TAB [8] = '{
        6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B
    };
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    logic       r_type;
    logic [7:0] hit;
    logic       is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic       is_mult, is_multu, is_div, is_divu;
    logic       hd, start, busy, signed_op, div_op, mf_valid;

    assign r_type = bus.en && (bus.op_c == 6'h00);

    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
        assign hit[gi] = r_type && (bus.funct == FUNCT_TAB[gi]);
    end

    assign is_mfhi  = hit[0];
    assign is_mthi  = hit[1];
    assign is_mflo  = hit[2];
    assign is_mtlo  = hit[3];
    assign is_mult  = hit[4];
    assign is_multu = hit[5];
    assign is_div   = hit[6];
    assign is_divu  = hit[7];

    assign start     = is_mult | is_multu | is_div | is_divu;
    assign hd        = |hit;
    assign busy      = (state_reg != ST_IDLE);
    assign signed_op = is_mult | is_div;
    assign div_op    = is_div | is_divu;
    assign mf_valid  = (is_mfhi | is_mflo) & ~busy;

    assign bus.busy     = busy;
    assign bus.stall    = hd & busy;
    assign bus.mf_valid = mf_valid;
    assign bus.mf_data  = mf_valid ? (is_mfhi ? hi_reg : lo_reg) : '0;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

    // The datapath always works on magnitudes; signs are reapplied in FIX.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = signed_op && bus.src_a[WIDTH-1];
    assign b_neg = signed_op && bus.src_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag = b_neg ? -bus.src_b : bus.src_b;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_acc;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_acc   = div_ge ? {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               div_zero;

    assign prod     = neg_q_reg ? -acc_reg : acc_reg;
    assign quo      = acc_reg[WIDTH-1:0];
    assign rem      = acc_reg[2*WIDTH-1:WIDTH];
    assign div_zero = (opnd_reg == '0);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = div_op ? ST_DIV : ST_MUL;
                    count_next  = COUNT_LOAD;
                    is_div_next = div_op;
                    neg_q_next  = a_neg ^ b_neg;
                    neg_r_next  = a_neg;
                    if (div_op) begin
                        acc_next  = {{WIDTH{1'b0}}, a_mag};
                        opnd_next = b_mag;
                    end else begin
                        acc_next  = {{WIDTH{1'b0}}, b_mag};
                        opnd_next = a_mag;
                    end
                end
                if (is_mthi) hi_next = bus.src_a;
                if (is_mtlo) lo_next = bus.src_a;
            end
            ST_MUL: begin
                acc_next   = mul_acc;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) state_next = ST_FIX;
            end
            ST_DIV: begin
                acc_next   = div_acc;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) state_next = ST_FIX;
            end
            ST_FIX: begin
                if (!is_div_reg) begin
                    {hi_next, lo_next} = prod;
                end else if (div_zero) begin
                    // Restoring against zero leaves all-ones and the dividend; keep raw.
                    lo_next = quo;
                    hi_next = rem;
                end else begin
                    lo_next = neg_q_reg ? -quo : quo;
                    hi_next = neg_r_reg ? -rem : rem;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized
// MULT/MULTU/DIV/DIVU against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    localparam int W = 32;
    localparam int LAT = W + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic clk, rst;
    int n_checks, n_fail;
    logic [W-1:0] exp_hi, exp_lo;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();
    muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: signed ops via 64-bit signed arithmetic (truncating division).
    // Signed divide-by-zero is only stimulated with a non-negative dividend.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (f)
            F_MULT:  res = 64'(sa * sb);
            F_MULTU: res = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bus.en    = e;
        bus.op_c  = 6'h00;
        bus.funct = f;
        bus.src_a = a;
        bus.src_b = b;
    endtask

    // Issues one start in cycle 0 and counts busy cycles (bounded).
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        next_cycle();
        drive(1'b1, f, a, b);
        next_cycle();
        drive(1'b0, 6'h00, '0, '0);
        lat = 0;
        sample();
        while (bus.busy === 1'b1 && lat < 60) begin
            lat++;
            next_cycle();
            sample();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 6'h00, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        n_checks++; if (bus.mf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mf_valid: got %b expected 0", bus.mf_valid); end
        n_checks++; if (bus.mf_data !== 32'h0) begin n_fail++; $display("FAIL reset_mf_data: got %h expected 0", bus.mf_data); end
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        $display("reset done");
    endtask

    task automatic test_mult_mflo_interlock();
        next_cycle();
        drive(1'b1, F_MULT, 32'd7, 32'hFFFF_FFFD);
        sample();
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mflo_start_stall: got %b expected 0", bus.stall); end
        next_cycle();
        drive(1'b1, F_MFLO, '0, '0);
        for (int k = 1; k <= LAT; k++) begin
            sample();
            n_checks++; if (bus.stall !== 1'b1 || bus.mf_valid !== 1'b0) begin
                n_fail++; $display("FAIL mflo_stall_c%0d: got stall=%b mf_valid=%b expected stall=1 mf_valid=0", k, bus.stall, bus.mf_valid);
            end
            n_checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                n_fail++; $display("FAIL mflo_hilo_hold_c%0d: got %h_%h expected %h_%h", k, bus.hi, bus.lo, exp_hi, exp_lo);
            end
            next_cycle();
        end
        sample();
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mflo_release_stall: got %b expected 0", bus.stall); end
        n_checks++; if (bus.mf_valid !== 1'b1) begin n_fail++; $display("FAIL mflo_valid: got %b expected 1", bus.mf_valid); end
        n_checks++; if (bus.mf_data !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mflo_data: got %h expected ffffffeb", bus.mf_data); end
        n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mflo_hi: got %h expected ffffffff", bus.hi); end
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFEB;
        next_cycle();
        drive(1'b0, 6'h00, '0, '0);
        $display("MULT 7 x -3 then MFLO: mf_data=%h", 32'hFFFF_FFEB);
    endtask

    task automatic test_mt_mf();
        next_cycle();
        drive(1'b1, F_MTHI, 32'h1234_5678, '0);
        sample();
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", bus.stall); end
        next_cycle();
        drive(1'b1, F_MFHI, '0, '0);
        sample();
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_stall: got %b expected 0", bus.stall); end
        n_checks++; if (bus.mf_valid !== 1'b1 || bus.mf_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL mfhi_data: got valid=%b data=%h expected valid=1 data=12345678", bus.mf_valid, bus.mf_data);
        end
        exp_hi = 32'h1234_5678;
        next_cycle();
        drive(1'b1, F_MTLO, 32'hCAFE_F00D, '0);
        next_cycle();
        drive(1'b1, F_MFLO, '0, '0);
        sample();
        n_checks++; if (bus.mf_valid !== 1'b1 || bus.mf_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mflo_after_mtlo: got valid=%b data=%h expected valid=1 data=cafef00d", bus.mf_valid, bus.mf_data);
        end
        exp_lo = 32'hCAFE_F00D;
        next_cycle();
        drive(1'b0, F_MFHI, '0, '0);
        sample();
        n_checks++; if (bus.mf_valid !== 1'b0 || bus.mf_data !== 32'h0) begin
            n_fail++; $display("FAIL mfhi_en_low: got valid=%b data=%h expected valid=0 data=0", bus.mf_valid, bus.mf_data);
        end
        next_cycle();
        drive(1'b0, F_MTHI, 32'hDEAD_BEEF, '0);
        next_cycle();
        drive(1'b1, F_MFHI, '0, '0);
        bus.op_c = 6'h01;
        sample();
        n_checks++; if (bus.mf_valid !== 1'b0) begin n_fail++; $display("FAIL mfhi_bad_opcode: got valid=%b expected 0", bus.mf_valid); end
        n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL mthi_en_low_write: got %h expected %h", bus.hi, exp_hi); end
        next_cycle();
        drive(1'b0, 6'h00, '0, '0);
        $display("MTHI/MFHI/MTLO/MFLO idle: hi=%h lo=%h", exp_hi, exp_lo);
    endtask

    task automatic test_non_hilo_no_stall();
        int lat;
        next_cycle();
        drive(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        next_cycle();
        lat = 0;
        for (int k = 1; k <= LAT; k++) begin
            drive(1'b1, (k % 2 == 0) ? F_ADD : F_MFHI, $urandom, $urandom);
            if (k % 2 != 0) bus.op_c = 6'h23;
            sample();
            if (bus.busy === 1'b1) lat++;
            n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL nonhilo_stall_c%0d: got %b expected 0", k, bus.stall); end
            next_cycle();
        end
        drive(1'b0, 6'h00, '0, '0);
        sample();
        n_checks++; if (lat != LAT || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL nonhilo_latency: got %0d busy=%b expected %0d busy=0", lat, bus.busy, LAT);
        end
        n_checks++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            n_fail++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo);
        end
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h0000_0001;
        $display("MULTU ffffffff x ffffffff with ADD traffic: hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_directed();
        logic [5:0]   f_t  [5];
        logic [W-1:0] a_t  [5];
        logic [W-1:0] b_t  [5];
        logic [W-1:0] hi_t [5];
        logic [W-1:0] lo_t [5];
        int lat;
        f_t = '{F_DIV, F_DIV, F_DIVU, F_DIV, F_MULT};
        a_t = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h64, 32'd100, 32'h8000_0000};
        b_t = '{32'd2, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000};
        hi_t = '{32'hFFFF_FFFF, 32'h0, 32'h64, 32'd100, 32'h4000_0000};
        lo_t = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 5; i++) begin
            run_op(f_t[i], a_t[i], b_t[i], lat);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (bus.hi !== hi_t[i] || bus.lo !== lo_t[i]) begin
                n_fail++; $display("FAIL directed%0d_result: got %h_%h expected %h_%h", i, bus.hi, bus.lo, hi_t[i], lo_t[i]);
            end
            exp_hi = hi_t[i];
            exp_lo = lo_t[i];
            $display("op %h a=%h b=%h -> hi=%h lo=%h lat=%0d", f_t[i], a_t[i], b_t[i], bus.hi, bus.lo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [63:0] r1, r2;
        int lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        r1 = ref_model(F_MULT, a1, b1);
        r2 = ref_model(F_MULTU, a2, b2);
        next_cycle();
        drive(1'b1, F_MULT, a1, b1);
        next_cycle();
        drive(1'b1, F_MULTU, a2, b2);
        for (int k = 1; k <= LAT; k++) begin
            sample();
            n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_c%0d: got %b expected 1", k, bus.stall); end
            next_cycle();
        end
        sample();
        n_checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got stall=%b busy=%b expected 0 0", bus.stall, bus.busy);
        end
        n_checks++; if ({bus.hi, bus.lo} !== r1) begin n_fail++; $display("FAIL b2b_first: got %h_%h expected %h", bus.hi, bus.lo, r1); end
        next_cycle();
        drive(1'b0, 6'h00, '0, '0);
        lat = 0;
        sample();
        while (bus.busy === 1'b1 && lat < 60) begin
            lat++;
            next_cycle();
            sample();
        end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if ({bus.hi, bus.lo} !== r2) begin n_fail++; $display("FAIL b2b_second: got %h_%h expected %h", bus.hi, bus.lo, r2); end
        {exp_hi, exp_lo} = r2;
        $display("back-to-back MULT then MULTU -> %h", r2);
    endtask

    task automatic test_random_ops();
        logic [5:0] ops [4];
        logic [5:0] f;
        logic [W-1:0] a, b;
        logic [63:0] r;
        int lat;
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = pick_operand();
            b = pick_operand();
            if (f == F_DIV && b == 0) a[W-1] = 1'b0;
            r = ref_model(f, a, b);
            run_op(f, a, b, lat);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if ({bus.hi, bus.lo} !== r) begin
                n_fail++; $display("FAIL rand%0d_result op=%h a=%h b=%h: got %h_%h expected %h", i, f, a, b, bus.hi, bus.lo, r);
            end
            {exp_hi, exp_lo} = r;
            $display("rand op %h a=%h b=%h -> hi=%h lo=%h", f, a, b, bus.hi, bus.lo);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        next_cycle();
        drive(1'b1, F_MULT, 32'h0001_2345, 32'hFFFF_0007);
        next_cycle();
        drive(1'b1, F_MFHI, '0, '0);
        repeat (9) next_cycle();
        #2;
        n_checks++; if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got stall=%b busy=%b expected 1 1", bus.stall, bus.busy);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL areset_ctrl: got busy=%b stall=%b expected 0 0", bus.busy, bus.stall);
        end
        n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++; $display("FAIL areset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        #1;
        rst = 1'b0;
        drive(1'b0, 6'h00, '0, '0);
        run_op(F_MULT, 32'd3, 32'd4, lat);
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL areset_fresh_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            n_fail++; $display("FAIL areset_fresh_mult: got %h_%h expected 00000000_0000000c", bus.hi, bus.lo);
        end
        $display("async reset mid-MULT, then MULT 3 x 4 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(1'b0, 6'h00, '0, '0);
        test_reset();
        test_mult_mflo_interlock();
        test_mt_mf();
        test_non_hilo_no_stall();
        test_directed();
        test_back_to_back();
        test_random_ops();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
